// File: rtl/npc_mem_pkg.sv
// ---------------------------------------------------------------------------
// npc_mem_pkg
// Shared widths and enumerations for the memory-port arbiter slice.
//   ADDR_W / DATA_W / INST_W / MASK_W : default bus widths
//   arb_state_t : arbiter transaction state (IDLE -> REQ -> RESP)
//   owner_t     : which requester owns the in-flight transaction
// ---------------------------------------------------------------------------
package npc_mem_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int INST_W = 32;
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_t;

endpackage

// File: rtl/mem_rr_arb2.sv
// ---------------------------------------------------------------------------
// mem_rr_arb2
// Two-way round-robin grant with a last-grant register.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector, bit 0 = IFU, bit 1 = LSU
//   accept     : the current grant was taken this cycle (updates last grant)
//   grant[1:0] : one-hot combinational grant, all-zero when nothing requests
// ---------------------------------------------------------------------------
module mem_rr_arb2
  import npc_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  owner_t lastGrant_q;
  owner_t lastGrant_d;

  // A lone requester always wins; on a tie the side that did not win
  // last time is preferred, so both sides alternate under contention.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (lastGrant_q == OWN_LSU) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Only a taken grant moves the round-robin pointer; an offered but
  // unused grant leaves the priority untouched.
  always_comb begin
    lastGrant_d = lastGrant_q;
    if (accept) begin
      lastGrant_d = grant[1] ? OWN_LSU : OWN_IFU;
    end
  end

  // Reset leaves the pointer on the LSU so the first tie goes to the IFU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGrant_q <= OWN_LSU;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one 64-bit memory port between the IFU and the LSU, one
// transaction at a time (IDLE -> REQ -> RESP).
//   clk, rst_n      : clock, asynchronous active-low reset
//   ifu_req_*       : fetch request (valid/ready/addr)
//   ifu_resp_*      : one-cycle instruction pulse, 32-bit instruction
//   lsu_req_*       : load/store request (valid/ready/addr/wen/wdata/wmask)
//   lsu_resp_*      : one-cycle load-data / store-ack pulse, 64-bit data
//   mem_req_*       : downstream request, held stable until mem_req_ready
//   mem_resp_*      : downstream response (valid/rdata)
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import npc_mem_pkg::*;
#(
  parameter int ADDR_W = npc_mem_pkg::ADDR_W,
  parameter int DATA_W = npc_mem_pkg::DATA_W,
  parameter int INST_W = npc_mem_pkg::INST_W,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_resp_valid,
  output logic [INST_W-1:0] ifu_resp_inst,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
);

  arb_state_t        state_q;
  owner_t            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic              ifuRespValid_q;
  logic              lsuRespValid_q;
  logic [INST_W-1:0] inst_q;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0] grant;
  logic       idle;
  logic       ifuHs;
  logic       lsuHs;
  logic       accept;

  assign idle = (state_q == IDLE);

  mem_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({lsu_req_valid, ifu_req_valid}),
    .accept (accept),
    .grant  (grant)
  );

  // Readiness is only offered while no transaction is outstanding.
  assign ifu_req_ready = idle & grant[0];
  assign lsu_req_ready = idle & grant[1];
  assign ifuHs         = ifu_req_valid & ifu_req_ready;
  assign lsuHs         = lsu_req_valid & lsu_req_ready;
  assign accept        = ifuHs | lsuHs;

  assign mem_req_valid  = (state_q == REQ);
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;
  assign ifu_resp_valid = ifuRespValid_q;
  assign ifu_resp_inst  = inst_q;
  assign lsu_resp_valid = lsuRespValid_q;
  assign lsu_resp_rdata = rdata_q;

  // Transaction FSM. The request payload is latched at acceptance so the
  // downstream port sees a stable request regardless of what the requester
  // does afterwards. Each requester keeps its own response register so a
  // response to one side never disturbs the data last shown to the other.
  // Response pulses default low every cycle, giving exactly one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      owner_q        <= OWN_LSU;
      addr_q         <= '0;
      wen_q          <= 1'b0;
      wdata_q        <= '0;
      wmask_q        <= '0;
      ifuRespValid_q <= 1'b0;
      lsuRespValid_q <= 1'b0;
      inst_q         <= '0;
      rdata_q        <= '0;
    end else begin
      ifuRespValid_q <= 1'b0;
      lsuRespValid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (lsuHs) begin
            state_q <= REQ;
            owner_q <= OWN_LSU;
            addr_q  <= lsu_req_addr;
            wen_q   <= lsu_req_wen;
            wdata_q <= lsu_req_wdata;
            wmask_q <= lsu_req_wmask;
          end else if (ifuHs) begin
            // Fetches are always reads with an empty byte mask.
            state_q <= REQ;
            owner_q <= OWN_IFU;
            addr_q  <= ifu_req_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (mem_resp_valid) begin
            state_q <= IDLE;
            if (owner_q == OWN_IFU) begin
              // Address bit 2 picks which 32-bit half of the beat holds
              // the instruction.
              ifuRespValid_q <= 1'b1;
              inst_q <= addr_q[2] ? mem_resp_rdata[2*INST_W-1:INST_W]
                                  : mem_resp_rdata[INST_W-1:0];
            end else begin
              lsuRespValid_q <= 1'b1;
              rdata_q        <= mem_resp_rdata;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Inputs are driven on the falling edge
// and outputs sampled 1 time unit later; the DUT registers on the rising edge.
// Accepted requests push the expected downstream payload to reqQ; response
// data driven by the memory side pushes the expected requester response to
// respQ, which is popped when the response pulse is due.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import npc_mem_pkg::*;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    bit          isLsu;
  } memReq_t;

  typedef struct {
    bit          isLsu;
    logic [63:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [63:0] ifu_req_addr = '0;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_inst;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic [63:0] lsu_req_addr = '0;
  logic        lsu_req_wen = 1'b0;
  logic [63:0] lsu_req_wdata = '0;
  logic [7:0]  lsu_req_wmask = '0;
  logic        lsu_resp_valid;
  logic [63:0] lsu_resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_rdata = '0;

  memReq_t reqQ[$];
  resp_t   respQ[$];
  int      compared = 0;
  int      mismatched = 0;
  int      memHs = 0;

  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  mem_port_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_inst  (ifu_resp_inst),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_wmask  (lsu_req_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_rdata (lsu_resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Counts downstream handshakes from the values present just before each edge.
  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) memHs++;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected end of sequence");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks the grant in the current (idle) cycle and records what the
  // downstream port must show for the side that is about to be accepted.
  task automatic applyStimulus(input bit expectLsu);
    memReq_t m;
    checkOutput("ifu_req_ready grant", ifu_req_ready, !expectLsu);
    checkOutput("lsu_req_ready grant", lsu_req_ready, expectLsu);
    if (expectLsu) begin
      m.addr = lsu_req_addr; m.wen = lsu_req_wen; m.wdata = lsu_req_wdata;
      m.wmask = lsu_req_wmask; m.isLsu = 1'b1;
    end else begin
      m.addr = ifu_req_addr; m.wen = 1'b0; m.wdata = '0;
      m.wmask = '0; m.isLsu = 1'b0;
    end
    reqQ.push_back(m);
  endtask

  // Plays the memory side of one accepted transaction. hold: 0 = requesters
  // drop valid right after acceptance, 1 = keep valid throughout,
  // 2 = keep valid until the response pulse cycle, then drop.
  task automatic serveMem(input int readyDelay, input int respDelay,
                          input logic [63:0] rdata, input int hold);
    memReq_t e;
    resp_t   r;
    int      hs0;
    checkOutput("reqQ depth", reqQ.size(), 1);
    e = reqQ.pop_front();
    hs0 = memHs;
    for (int i = 0; i <= readyDelay; i++) begin
      @(negedge clk);
      if (i == 0 && hold == 0) begin
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
      end
      mem_req_ready  = (i == readyDelay);
      mem_resp_valid = (i < readyDelay);
      mem_resp_rdata = JUNK;
      #1;
      checkOutput("mem_req_valid REQ", mem_req_valid, 1'b1);
      checkOutput("mem_req_addr", mem_req_addr, e.addr);
      checkOutput("mem_req_wen", mem_req_wen, e.wen);
      checkOutput("mem_req_wdata", mem_req_wdata, e.wdata);
      checkOutput("mem_req_wmask", mem_req_wmask, e.wmask);
      checkOutput("ifu_req_ready busy", ifu_req_ready, 1'b0);
      checkOutput("lsu_req_ready busy", lsu_req_ready, 1'b0);
      checkOutput("resp pulses in REQ", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    end
    for (int i = 0; i <= respDelay; i++) begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = (i == respDelay);
      mem_resp_rdata = (i == respDelay) ? rdata : JUNK;
      #1;
      checkOutput("mem_req_valid RESP", mem_req_valid, 1'b0);
      checkOutput("ifu_req_ready RESP", ifu_req_ready, 1'b0);
      checkOutput("lsu_req_ready RESP", lsu_req_ready, 1'b0);
      checkOutput("resp pulses in RESP", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    end
    checkOutput("mem handshake count", memHs - hs0, 1);
    r.isLsu = e.isLsu;
    if (e.isLsu) r.data = rdata;
    else         r.data = e.addr[2] ? {32'h0, rdata[63:32]} : {32'h0, rdata[31:0]};
    respQ.push_back(r);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_rdata = JUNK;
    if (hold == 2) begin
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
    end
    #1;
    r = respQ.pop_front();
    checkOutput("ifu_resp_valid pulse", ifu_resp_valid, !r.isLsu);
    checkOutput("lsu_resp_valid pulse", lsu_resp_valid, r.isLsu);
    if (r.isLsu) checkOutput("lsu_resp_rdata", lsu_resp_rdata, r.data);
    else         checkOutput("ifu_resp_inst", {32'h0, ifu_resp_inst}, r.data);
  endtask

  // One quiet cycle: pulses must have ended and nothing is offered readiness.
  task automatic idleCheck(input string tag);
    @(negedge clk);
    #1;
    checkOutput({tag, " resp pulses"}, {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    checkOutput({tag, " readies"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
    checkOutput({tag, " mem_req_valid"}, mem_req_valid, 1'b0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " readies"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
    checkOutput({tag, " resp valids"}, {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    checkOutput({tag, " ifu_resp_inst"}, {32'h0, ifu_resp_inst}, 64'h0);
    checkOutput({tag, " lsu_resp_rdata"}, lsu_resp_rdata, 64'h0);
    checkOutput({tag, " mem_req_valid"}, mem_req_valid, 1'b0);
    checkOutput({tag, " mem_req_addr"}, mem_req_addr, 64'h0);
    checkOutput({tag, " mem_req_wen"}, mem_req_wen, 1'b0);
    checkOutput({tag, " mem_req_wdata"}, mem_req_wdata, 64'h0);
    checkOutput({tag, " mem_req_wmask"}, {56'h0, mem_req_wmask}, 64'h0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Tie out of reset: IFU, LSU, IFU, LSU, each accepted in the previous
    // response-pulse cycle while both sides hold their requests.
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0008;
    lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_0100;
    lsu_req_wen = 1'b0; lsu_req_wdata = 64'h0; lsu_req_wmask = 8'h00;
    #1;
    applyStimulus(1'b0);
    serveMem(0, 0, 64'h1111_2222_3333_4444, 1);
    applyStimulus(1'b1);
    serveMem(0, 0, 64'hCAFE_F00D_0123_4567, 1);
    applyStimulus(1'b0);
    serveMem(0, 0, 64'h5555_6666_7777_8888, 1);
    applyStimulus(1'b1);
    serveMem(0, 0, 64'h0F0F_1E1E_2D2D_3C3C, 2);
    idleCheck("after tie");

    // IFU fetch from the upper half of the beat, minimum latency.
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0004;
    #1;
    applyStimulus(1'b0);
    serveMem(0, 0, 64'h1234_5678_9ABC_DEF0, 0);
    idleCheck("fetch hi");

    // IFU fetch from the lower half of the same beat.
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0000;
    #1;
    applyStimulus(1'b0);
    serveMem(0, 0, 64'h1234_5678_9ABC_DEF0, 0);
    idleCheck("fetch lo");

    // LSU store with the downstream port stalled for 4 cycles; stray
    // mem_resp_valid during the stall must be ignored.
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_req_addr = 64'h8000_0010;
    lsu_req_wen = 1'b1; lsu_req_wdata = 64'hAA; lsu_req_wmask = 8'h01;
    #1;
    applyStimulus(1'b1);
    serveMem(4, 0, 64'h0000_0000_5555_5555, 0);
    idleCheck("store");

    // Slow memory while the IFU keeps requesting: no second acceptance.
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0104;
    #1;
    applyStimulus(1'b0);
    serveMem(0, 10, 64'h7654_3210_FEDC_BA98, 2);
    idleCheck("slow");

    // A response with nothing outstanding is ignored and data holds.
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_rdata = JUNK;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    checkOutput("idle resp pulses", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    checkOutput("ifu_resp_inst hold", {32'h0, ifu_resp_inst}, 64'h7654_3210);
    checkOutput("lsu_resp_rdata hold", lsu_resp_rdata, 64'h0000_0000_5555_5555);

    // Reset while waiting for a response; the late response is dropped.
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_req_addr = 64'h8000_0204;
    #1;
    applyStimulus(1'b0);
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    checkOutput("rst-test mem_req_valid", mem_req_valid, 1'b1);
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    checkOutput("rst-test in RESP", mem_req_valid, 1'b0);
    #1;
    rst_n = 1'b0;
    reqQ.delete();
    #1;
    checkResetOutputs("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFFFF_EEEE_DDDD_CCCC;
    #1;
    checkOutput("post-reset no pulse", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    checkResetOutputs("post-reset");
    idleCheck("post-reset");

    // Priority pointer is back on the LSU: a tie offers the IFU first.
    @(negedge clk);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #1;
    checkOutput("post-reset tie ifu", ifu_req_ready, 1'b1);
    checkOutput("post-reset tie lsu", lsu_req_ready, 1'b0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    idleCheck("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 64-bit physical memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time from either side and drives it onto the downstream memory port.
- Waits for the response and returns it to the requester that owns the transaction.
- For IFU responses, extracts the 32-bit instruction from the 64-bit beat using address bit 2.

Parameters:
- ADDR_W, 64, address width of all request ports
- DATA_W, 64, memory data width
- INST_W, 32, instruction width returned to the IFU
- MASK_W, DATA_W/8, byte write-mask width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  fetch address (pc)
- ifu_resp_valid  out  1  one-cycle pulse, instruction valid
- ifu_resp_inst  out  INST_W  fetched instruction
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  ADDR_W  load/store address
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_wdata  in  DATA_W  store data
- lsu_req_wmask  in  MASK_W  store byte mask
- lsu_resp_valid  out  1  one-cycle pulse, load data / store ack
- lsu_resp_rdata  out  DATA_W  load data
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts request
- mem_req_addr  out  ADDR_W  downstream address
- mem_req_wen  out  1  downstream write enable
- mem_req_wdata  out  DATA_W  downstream write data
- mem_req_wmask  out  MASK_W  downstream byte mask
- mem_resp_valid  in  1  downstream response valid
- mem_resp_rdata  in  DATA_W  downstream read data

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, last_grant = LSU.
  - All *_valid and *_ready outputs = 0.
  - All data/address outputs = 0.
  - Any in-flight transaction is discarded; no response pulse is produced after reset releases.
- States: IDLE, REQ, RESP; at most one outstanding transaction.
- IDLE:
  - Grant is combinational:
    - only one valid → that side wins;
    - both valid → the side not equal to last_grant wins (round-robin).
  - Winner's *_req_ready = 1 and the loser's = 0. Both readies = 0 when neither side is valid.
  - On handshake (valid & ready), at the clock edge:
    - latch addr/wen/wdata/wmask and owner;
    - last_grant <= owner;
    - go to REQ.
  - IFU requests latch wen = 0 and wmask = 0.
- REQ:
  - mem_req_valid = 1; mem_req_* driven from the latched registers and held stable until mem_req_ready.
  - On mem_req_valid & mem_req_ready → RESP.
  - mem_resp_valid in REQ is ignored.
- RESP:
  - mem_req_valid = 0.
  - On mem_resp_valid, at the edge:
    - register response data;
    - next cycle pulse the owner's resp_valid for exactly one cycle;
    - state <= IDLE at the same edge.
  - A new request may be accepted in the cycle the response pulse is visible.
- IFU data: ifu_resp_inst = latched_addr[2] ? rdata[63:32] : rdata[31:0]. Address bits [1:0] are not checked.
- LSU data: lsu_resp_rdata = full registered rdata; a store also pulses lsu_resp_valid (ack) and carries whatever rdata memory returned.
- Response data outputs hold their last value between pulses. The non-owner's resp_valid is never asserted.
- Minimum latency, with mem_req_ready = 1 and mem_resp_valid the cycle after acceptance:
  - req handshake edge 0;
  - mem_req_valid in cycle 1;
  - mem_resp_valid in cycle 2;
  - resp_valid in cycle 3.
- Requesters must hold valid/payload until ready; a request withdrawn before ready is never issued.
- mem_resp_valid in IDLE is ignored.

Decomposition:
- Package npc_mem_pkg holds:
  - ADDR_W/DATA_W/INST_W constants;
  - arb_state_t enum {IDLE, REQ, RESP};
  - owner_t enum {OWN_IFU, OWN_LSU}.
- Sub-module mem_rr_arb2 holds the 2-way round-robin grant logic and the last_grant register. Inputs: req[1:0], accept. Output: one-hot grant[1:0].

Test Plan:
- IFU-only fetch: addr 0x8000_0004, memory returns 0x1234_5678_9ABC_DEF0 → ifu_resp_inst = 0x1234_5678, single-cycle pulse, latency 3 cycles.
- IFU fetch at 0x8000_0000, same data → inst = 0x9ABC_DEF0; lsu_resp_valid stays 0.
- Simultaneous IFU and LSU requests out of reset, both held → IFU granted first, then LSU, then IFU again, alternating on every tie.
- LSU store, addr 0x8000_0010, wdata 0xAA, wmask 0x01 → mem_req_wen = 1 and mask/data held until mem_req_ready; ready stalled 4 cycles keeps payload stable; ack pulse on lsu_resp_valid.
- Slow memory (mem_resp_valid 10 cycles after accept) while IFU keeps requesting → ifu_req_ready = 0 throughout; only one mem_req handshake occurs.
- rst_n asserted in RESP, then mem_resp_valid arrives after release → no resp_valid pulse, state IDLE, outputs 0.
